// File: rtl/unidade_controle.sv
// Multicycle control unit: holds IR, decodes opcode + Tstep into one-hot datapath/memory strobes.
// Optional macro CONTROLE_MVNZ_EN enables mvnz (opcode 110); without it 110 behaves as reserved.
module unidade_controle (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Run,
    input  logic [2:0] Tstep,
    input  logic [8:0] DIN,
    input  logic       G_zero,
    output logic       Clear,
    output logic       Done,
    output logic [8:0] IR,
    output logic [7:0] Rin,
    output logic [7:0] Rout,
    output logic       Ain,
    output logic       Gin,
    output logic       Gout,
    output logic       AddSub,
    output logic       DINout,
    output logic       ADDRin,
    output logic       DOUTin,
    output logic       W_D,
    output logic       incr_pc,
    output logic       Erro
);

    typedef enum logic [2:0] {
        OP_MV   = 3'd0,
        OP_MVI  = 3'd1,
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_LD   = 3'd4,
        OP_ST   = 3'd5,
        OP_MVNZ = 3'd6,
        OP_RSV  = 3'd7
    } opcode_e;

    logic [8:0] ir_q, ir_d;
    logic       erro_q, erro_d;
    opcode_e    op;
    logic [7:0] x_oh, y_oh;
    logic       active, watchdog, is_reserved, rsv_exec;

    assign op   = opcode_e'(ir_q[8:6]);
    assign x_oh = 8'b1 << ir_q[5:3];
    assign y_oh = 8'b1 << ir_q[2:0];

    // Reset suppresses every strobe so no memory write can slip out mid-reset
    assign active   = Run & ~Reset;
    assign watchdog = Run & (Tstep >= 3'd6);

`ifdef CONTROLE_MVNZ_EN
    assign is_reserved = (op == OP_RSV);
`else
    logic unused_g_zero;
    assign unused_g_zero = G_zero;
    assign is_reserved   = (op == OP_RSV) | (op == OP_MVNZ);
`endif

    assign rsv_exec = active & (Tstep == 3'd3) & is_reserved;

    always_comb begin
        ir_d   = ir_q;
        erro_d = erro_q | rsv_exec;
        if (Run && (Tstep == 3'd2)) begin
            ir_d = DIN;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            ir_q   <= 9'b0;
            erro_q <= 1'b0;
        end else begin
            ir_q   <= ir_d;
            erro_q <= erro_d;
        end
    end

    always_comb begin
        Done    = 1'b0;
        Rin     = 8'b0;
        Rout    = 8'b0;
        Ain     = 1'b0;
        Gin     = 1'b0;
        Gout    = 1'b0;
        AddSub  = 1'b0;
        DINout  = 1'b0;
        ADDRin  = 1'b0;
        DOUTin  = 1'b0;
        W_D     = 1'b0;
        incr_pc = 1'b0;
        if (active && !watchdog) begin
            if (Tstep == 3'd0) begin
                Rout[7] = 1'b1;
                ADDRin  = 1'b1;
                incr_pc = 1'b1;
            end else if (is_reserved) begin
                Done = (Tstep == 3'd3);
            end else begin
                case (op)
                    OP_MV: begin
                        if (Tstep == 3'd3) begin
                            Rin  = x_oh;
                            Rout = y_oh;
                            Done = 1'b1;
                        end
                    end
                    OP_MVI: begin
                        if (Tstep == 3'd3) begin
                            Rout[7] = 1'b1;
                            ADDRin  = 1'b1;
                            incr_pc = 1'b1;
                        end else if (Tstep == 3'd5) begin
                            DINout = 1'b1;
                            Rin    = x_oh;
                            Done   = 1'b1;
                        end
                    end
                    OP_ADD, OP_SUB: begin
                        if (Tstep == 3'd3) begin
                            Rout = x_oh;
                            Ain  = 1'b1;
                        end else if (Tstep == 3'd4) begin
                            Rout   = y_oh;
                            Gin    = 1'b1;
                            AddSub = ir_q[6];
                        end else if (Tstep == 3'd5) begin
                            Gout = 1'b1;
                            Rin  = x_oh;
                            Done = 1'b1;
                        end
                    end
                    OP_LD: begin
                        if (Tstep == 3'd3) begin
                            Rout   = y_oh;
                            ADDRin = 1'b1;
                        end else if (Tstep == 3'd5) begin
                            DINout = 1'b1;
                            Rin    = x_oh;
                            Done   = 1'b1;
                        end
                    end
                    OP_ST: begin
                        if (Tstep == 3'd3) begin
                            Rout   = y_oh;
                            ADDRin = 1'b1;
                        end else if (Tstep == 3'd4) begin
                            Rout   = x_oh;
                            DOUTin = 1'b1;
                        end else if (Tstep == 3'd5) begin
                            W_D  = 1'b1;
                            Done = 1'b1;
                        end
                    end
`ifdef CONTROLE_MVNZ_EN
                    OP_MVNZ: begin
                        if (Tstep == 3'd3) begin
                            Done = 1'b1;
                            if (!G_zero) begin
                                Rin  = x_oh;
                                Rout = y_oh;
                            end
                        end
                    end
`endif
                    default: begin
                    end
                endcase
            end
        end
    end

    assign Clear = Done | Reset | watchdog;
    assign IR    = ir_q;
    assign Erro  = erro_q;

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Instruction-sequencing control unit for the multicycle processor. Consumes the 3-bit step count `Tstep` from the step counter and drives that counter's `Clear` to end each instruction. Holds the instruction register and decodes opcode plus step into the one-hot register-file, ALU, memory and PC strobes. Sits between the step counter, the datapath bus multiplexer and the synchronous instruction/data memory.

## Interface
- No parameters. Register count is fixed at 8 (R0–R7); R7 is the PC.
- `Clock`  in  1  system clock; all state updates on the rising edge
- `Reset`  in  1  synchronous, active-high reset
- `Run`  in  1  processor enable; when 0, every strobe output is 0
- `Tstep`  in  3  current step from the step counter (T0–T7)
- `DIN`  in  9  memory read data; carries the instruction word during fetch
- `G_zero`  in  1  1 when the G register equals 0
- `Clear`  out  1  step-counter clear request
- `Done`  out  1  final step of the current instruction
- `IR`  out  9  registered instruction, in the order opcode[8:6], X[5:3], Y[2:0]
- `Rin`  out  8  one-hot register write enables
- `Rout`  out  8  one-hot register bus-drive enables
- `Ain`, `Gin`, `Gout`, `AddSub`, `DINout`  out  1 each  datapath strobes; `AddSub` is 1 for subtract
- `ADDRin`, `DOUTin`, `W_D`, `incr_pc`  out  1 each  memory and PC strobes
- `Erro`  out  1  sticky flag, set when a reserved opcode executes

## Operation
- Opcodes:
  - 000 mv
  - 001 mvi
  - 010 add
  - 011 sub
  - 100 ld
  - 101 st
  - 110 mvnz
  - 111 reserved
- Fetch, common to every opcode:
  - T0: `Rout[7]`, `ADDRin`, `incr_pc`
  - T1: no strobes (memory latency)
  - T2: IR ← `DIN` on the rising edge
- Execute, steps T3–T5 (X and Y are decoded to one-hot):
  - mv: T3 `Rin[X]`, `Rout[Y]`, `Done`
  - mvi: T3 `Rout[7]`, `ADDRin`, `incr_pc`; T4 wait; T5 `DINout`, `Rin[X]`, `Done`
  - add/sub: T3 `Rout[X]`, `Ain`; T4 `Rout[Y]`, `Gin`, `AddSub` = opcode[6]; T5 `Gout`, `Rin[X]`, `Done`
  - ld: T3 `Rout[Y]`, `ADDRin`; T4 wait; T5 `DINout`, `Rin[X]`, `Done`
  - st: T3 `Rout[Y]`, `ADDRin`; T4 `Rout[X]`, `DOUTin`; T5 `W_D`, `Done`
  - mvnz: T3 `Done`; when `G_zero` = 0, also `Rin[X]` and `Rout[Y]`
  - reserved: T3 `Done`; `Erro` is set on the same edge
- `Clear` = `Done` OR `Reset` OR watchdog.
- Watchdog: `Tstep` ≥ 6 with `Run` = 1 forces `Clear`, with all strobes held at 0.
- At most one bit of `Rout`, and at most one bus source overall (`Rout`, `Gout`, `DINout`), is active in any cycle.
- Strobes and `Done` are combinational from `Tstep`, `IR`, `Run` and `G_zero`. `IR` and `Erro` are the only state.

## Timing
- Reset values: `IR` = 9'b0, `Erro` = 0, `Clear` = 1, all other outputs 0.
- `IR` updates only on the rising edge ending T2, with `Run` = 1 and `Reset` = 0.
- Instruction length:
  - 4 cycles: mv, mvnz, reserved
  - 6 cycles: mvi, add, sub, ld, st
- `Done` and `Clear` are high for exactly the final-step cycle. The counter shows T0 on the next cycle.
- When `Run` falls mid-instruction:
  - strobes drop to 0 in the same cycle
  - `IR` holds its value
  - execution resumes at the current `Tstep` when `Run` returns
- Reset mid-instruction: `IR` and `Erro` clear on the next edge; no memory write is issued (`W_D` = 0 while `Reset` = 1).
- Simultaneous IR load and `Reset`: `Reset` wins.

## Configuration
- Macro `CONTROLE_MVNZ_EN`.
- Defined: opcode 110 executes mvnz as specified.
- Undefined: opcode 110 is treated as reserved (4 cycles, `Done` at T3, `Erro` set), and `G_zero` is ignored.

## Test plan
- mvi R3,#0x1A: `DIN` = 001_011_000 at T2, then 0x1A at T5 → T5 shows `DINout` = 1 and `Rin` = 8'b0000_1000; `incr_pc` pulses at T0 and T3; `Done` at T5.
- sub R1,R2 (IR = 011_001_010) → `Rout` = 8'b0000_0010 with `Ain` at T3; `Rout` = 8'b0000_0100 with `Gin` and `AddSub` = 1 at T4; `Gout` with `Rin` = 8'b0000_0010 at T5.
- mvnz R4,R5 run twice, with `G_zero` = 1 then 0 → T3 `Rin` = 0 in the first run and `Rin` = 8'b0001_0000 in the second; `Done` = 1 in both. With the macro undefined: no `Rin` in either run, and `Erro` = 1.
- st R0,R6 (101_000_110) → T3 `Rout[6]` with `ADDRin`; T4 `Rout[0]` with `DOUTin`; T5 `W_D` = 1 for one cycle only.
- Reserved opcode 111 → `Done` at T3; `Erro` = 1 from the next cycle and held until `Reset`.
- `Reset` asserted at T4 of ld → `Clear` = 1 and `W_D` = 0 during reset; `IR` = 0 one edge later; after `Reset` falls, the next instruction fetches from T0.
